// File: rtl/signed_fxp_divider.sv
// Signed fixed-point divider with AXI-Stream operand and result channels.
// Uses a restoring radix-2 loop with a fixed latency of DATA_W+FRAC_W+1 cycles from accept to tvalid.
module signed_fxp_divider #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [DATA_W-1:0]          s_axis_dividend_tdata,
    input  logic                       s_axis_dividend_tvalid,
    output logic                       s_axis_dividend_tready,
    input  logic [DATA_W-1:0]          s_axis_divisor_tdata,
    input  logic                       s_axis_divisor_tvalid,
    output logic                       s_axis_divisor_tready,
    output logic [DATA_W+FRAC_W-1:0]   m_axis_dout_tdata,
    output logic [1:0]                 m_axis_dout_tuser,
    output logic                       m_axis_dout_tvalid,
    input  logic                       m_axis_dout_tready
);
    localparam int OUT_W = DATA_W + FRAC_W;
    localparam int N     = OUT_W;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_tready;
    logic                r_sign;
    logic                r_dbz;
    logic                r_dvd_neg;
    logic [N-1:0]        r_num;
    logic [DATA_W-1:0]   r_den;
    logic [DATA_W:0]     r_rem;
    logic [N-1:0]        r_mag;
    logic [CNT_W-1:0]    r_cnt;
    logic [OUT_W-1:0]    r_tdata;
    logic [1:0]          r_tuser;
    logic                r_tvalid;

    logic                w_accept;
    logic                w_last;
    logic [DATA_W-1:0]   w_dvd_abs;
    logic [DATA_W-1:0]   w_dvs_abs;
    logic [DATA_W:0]     w_trial;
    logic                w_ge;
    logic [DATA_W:0]     w_rem_next;
    logic [N-1:0]        w_mag_neg;
    logic [N-1:0]        w_pos_max;
    logic [N-1:0]        w_neg_min;

    assign w_accept  = r_tready & s_axis_dividend_tvalid & s_axis_divisor_tvalid;
    assign w_last    = (r_cnt == CNT_W'(N - 1));

    // Magnitudes as unsigned: the most negative input maps to 2^(DATA_W-1), which still fits.
    assign w_dvd_abs = s_axis_dividend_tdata[DATA_W-1] ? (~s_axis_dividend_tdata + DATA_W'(1))
                                                        : s_axis_dividend_tdata;
    assign w_dvs_abs = s_axis_divisor_tdata[DATA_W-1]  ? (~s_axis_divisor_tdata + DATA_W'(1))
                                                        : s_axis_divisor_tdata;

    // Remainder stays below the divisor, so its low DATA_W bits plus the next numerator bit never lose data.
    assign w_trial    = {r_rem[DATA_W-1:0], r_num[N-1]};
    assign w_ge       = (w_trial >= {1'b0, r_den});
    assign w_rem_next = w_ge ? (w_trial - {1'b0, r_den}) : w_trial;

    assign w_mag_neg  = ~r_mag + N'(1);
    assign w_pos_max  = {1'b0, {(N-1){1'b1}}};
    assign w_neg_min  = {1'b1, {(N-1){1'b0}}};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)           w_state_next = S_CALC;
            S_CALC:  if (w_last)             w_state_next = S_FIX;
            S_FIX:                           w_state_next = S_DONE;
            S_DONE:  if (m_axis_dout_tready) w_state_next = S_IDLE;
            default:                         w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tready  <= 1'b0;
            r_sign    <= 1'b0;
            r_dbz     <= 1'b0;
            r_dvd_neg <= 1'b0;
            r_num     <= '0;
            r_den     <= '0;
            r_rem     <= '0;
            r_mag     <= '0;
            r_cnt     <= '0;
            r_tdata   <= '0;
            r_tuser   <= '0;
            r_tvalid  <= 1'b0;
        end else begin
            r_tready <= (w_state_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign    <= s_axis_dividend_tdata[DATA_W-1] ^ s_axis_divisor_tdata[DATA_W-1];
                        r_dvd_neg <= s_axis_dividend_tdata[DATA_W-1];
                        r_dbz     <= (s_axis_divisor_tdata == '0);
                        r_num     <= N'(w_dvd_abs) << FRAC_W;
                        r_den     <= w_dvs_abs;
                        r_rem     <= '0;
                        r_mag     <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_num <= r_num << 1;
                    r_mag <= {r_mag[N-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (r_dbz) begin
                        r_tdata <= r_dvd_neg ? w_neg_min : w_pos_max;
                        r_tuser <= 2'b10;
                    end else if (!r_sign && (r_mag == w_neg_min)) begin
                        r_tdata <= w_pos_max;
                        r_tuser <= 2'b01;
                    end else begin
                        r_tdata <= r_sign ? w_mag_neg : r_mag;
                        r_tuser <= 2'b00;
                    end
                    r_tvalid <= 1'b1;
                end
                S_DONE: begin
                    if (m_axis_dout_tready) begin
                        r_tvalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_axis_dividend_tready = r_tready;
    assign s_axis_divisor_tready  = r_tready;
    assign m_axis_dout_tdata      = r_tdata;
    assign m_axis_dout_tuser      = r_tuser;
    assign m_axis_dout_tvalid     = r_tvalid;

endmodule

// File: tb/tb_signed_fxp_divider.sv
// Bench for signed_fxp_divider: directed test-plan vectors, handshake/backpressure/reset scenarios, random pairs vs. arithmetic model.
module tb_signed_fxp_divider;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 16;
    localparam int OUT_W  = DATA_W + FRAC_W;
    localparam int LAT    = OUT_W + 1;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [DATA_W-1:0] s_axis_dividend_tdata = '0;
    logic              s_axis_dividend_tvalid = 1'b0;
    logic              s_axis_dividend_tready;
    logic [DATA_W-1:0] s_axis_divisor_tdata = '0;
    logic              s_axis_divisor_tvalid = 1'b0;
    logic              s_axis_divisor_tready;
    logic [OUT_W-1:0]  m_axis_dout_tdata;
    logic [1:0]        m_axis_dout_tuser;
    logic              m_axis_dout_tvalid;
    logic              m_axis_dout_tready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    signed_fxp_divider #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
        .aclk                   (aclk),
        .aresetn                (aresetn),
        .s_axis_dividend_tdata  (s_axis_dividend_tdata),
        .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
        .s_axis_dividend_tready (s_axis_dividend_tready),
        .s_axis_divisor_tdata   (s_axis_divisor_tdata),
        .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
        .s_axis_divisor_tready  (s_axis_divisor_tready),
        .m_axis_dout_tdata      (m_axis_dout_tdata),
        .m_axis_dout_tuser      (m_axis_dout_tuser),
        .m_axis_dout_tvalid     (m_axis_dout_tvalid),
        .m_axis_dout_tready     (m_axis_dout_tready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Reference: exact quotient of dividend*2^FRAC_W / divisor, truncated toward zero, then saturated.
    function automatic void ref_div(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b,
                                    output logic [OUT_W-1:0] q, output logic [1:0] u);
        longint num;
        longint qq;
        if (b == 0) begin
            q = (a < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            u = 2'b10;
        end else begin
            num = longint'(a) * (longint'(1) << FRAC_W);
            qq  = num / longint'(b);
            if (qq > 64'sh7FFF_FFFF) begin
                q = 32'h7FFF_FFFF;
                u = 2'b01;
            end else begin
                q = qq[OUT_W-1:0];
                u = 2'b00;
            end
        end
    endfunction

    task automatic run_op(input string tag, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [OUT_W-1:0] exp_q, input logic [1:0] exp_u);
        int n;
        s_axis_dividend_tdata  = a;
        s_axis_divisor_tdata   = b;
        s_axis_dividend_tvalid = 1'b1;
        s_axis_divisor_tvalid  = 1'b1;
        n = 0;
        while (!s_axis_dividend_tready && n < 200) begin
            step();
            n++;
        end
        check({tag, "_accept_wait"}, 64'(n < 200), 64'(1));
        step();
        s_axis_dividend_tvalid = 1'b0;
        s_axis_divisor_tvalid  = 1'b0;
        check({tag, "_busy_tready"}, 64'(s_axis_divisor_tready), 64'(0));
        n = 0;
        while (!m_axis_dout_tvalid && n < 200) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        check({tag, "_tdata"}, 64'(m_axis_dout_tdata), 64'(exp_q));
        check({tag, "_tuser"}, 64'(m_axis_dout_tuser), 64'(exp_u));
        step();
        check({tag, "_tvalid_drop"}, 64'(m_axis_dout_tvalid), 64'(0));
        check({tag, "_tready_back"}, 64'(s_axis_dividend_tready), 64'(1));
        $display("op %s: %h / %h -> %h user %b", tag, a, b, m_axis_dout_tdata, m_axis_dout_tuser);
    endtask

    initial begin
        logic [OUT_W-1:0] rq;
        logic [1:0]       ru;
        logic [DATA_W-1:0] ra;
        logic [DATA_W-1:0] rb;
        logic             saw_valid;
        int               n;

        // Reset state
        repeat (3) step();
        check("rst_tvalid", 64'(m_axis_dout_tvalid), 64'(0));
        check("rst_tdata",  64'(m_axis_dout_tdata),  64'(0));
        check("rst_tuser",  64'(m_axis_dout_tuser),  64'(0));
        check("rst_tready", 64'(s_axis_dividend_tready), 64'(0));
        aresetn = 1'b1;
        #1;
        check("rel_tready_before_edge", 64'(s_axis_dividend_tready), 64'(0));
        step();
        check("rel_tready_after_edge", 64'(s_axis_dividend_tready), 64'(1));
        check("rel_divisor_tready", 64'(s_axis_divisor_tready), 64'(1));

        // Directed test-plan vectors
        run_op("7_div_2",       16'h0007, 16'h0002, 32'h0003_8000, 2'b00);
        run_op("m7_div_2",      16'hFFF9, 16'h0002, 32'hFFFC_8000, 2'b00);
        run_op("m1_div_3",      16'hFFFF, 16'h0003, 32'hFFFF_AAAB, 2'b00);
        run_op("5_div_0",       16'h0005, 16'h0000, 32'h7FFF_FFFF, 2'b10);
        run_op("m5_div_0",      16'hFFFB, 16'h0000, 32'h8000_0000, 2'b10);
        run_op("0_div_0",       16'h0000, 16'h0000, 32'h7FFF_FFFF, 2'b10);
        run_op("min_div_m1",    16'h8000, 16'hFFFF, 32'h7FFF_FFFF, 2'b01);
        run_op("min_div_1",     16'h8000, 16'h0001, 32'h8000_0000, 2'b00);

        // Dividend alone is never consumed; then backpressure on the result channel
        m_axis_dout_tready     = 1'b0;
        s_axis_dividend_tdata  = 16'hFFFF;
        s_axis_divisor_tdata   = 16'h0003;
        s_axis_dividend_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("lone_dividend_tready", 64'(s_axis_dividend_tready), 64'(1));
            check("lone_dividend_tvalid", 64'(m_axis_dout_tvalid), 64'(0));
        end
        s_axis_divisor_tvalid = 1'b1;
        step();
        s_axis_dividend_tvalid = 1'b0;
        s_axis_divisor_tvalid  = 1'b0;
        check("pair_accept_tready", 64'(s_axis_dividend_tready), 64'(0));
        n = 0;
        while (!m_axis_dout_tvalid && n < 200) begin
            step();
            n++;
        end
        check("bp_latency", 64'(n), 64'(LAT));
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_tvalid", 64'(m_axis_dout_tvalid), 64'(1));
            check("bp_tdata",  64'(m_axis_dout_tdata),  64'(32'hFFFF_AAAB));
            check("bp_tuser",  64'(m_axis_dout_tuser),  64'(0));
            check("bp_s_tready", 64'(s_axis_dividend_tready), 64'(0));
        end
        m_axis_dout_tready = 1'b1;
        step();
        check("bp_release_tvalid", 64'(m_axis_dout_tvalid), 64'(0));
        check("bp_release_tready", 64'(s_axis_dividend_tready), 64'(1));
        $display("op backpressure: ffff / 0003 held 10 cycles then transferred");

        // Reset in the middle of CALC
        s_axis_dividend_tdata  = 16'h0007;
        s_axis_divisor_tdata   = 16'h0002;
        s_axis_dividend_tvalid = 1'b1;
        s_axis_divisor_tvalid  = 1'b1;
        step();
        s_axis_dividend_tvalid = 1'b0;
        s_axis_divisor_tvalid  = 1'b0;
        repeat (10) step();
        aresetn = 1'b0;
        #1;
        check("midrst_tvalid", 64'(m_axis_dout_tvalid), 64'(0));
        check("midrst_tready", 64'(s_axis_dividend_tready), 64'(0));
        repeat (2) step();
        aresetn = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m_axis_dout_tvalid) saw_valid = 1'b1;
        end
        check("midrst_no_stale", 64'(saw_valid), 64'(0));
        $display("op midreset: in-flight 7/2 discarded");
        run_op("100_div_m3", 16'd100, 16'hFFFD, 32'hFFDE_AAAB, 2'b00);

        // Random pairs against the arithmetic model
        for (int i = 0; i < 200; i++) begin
            ra = DATA_W'($urandom);
            rb = DATA_W'($urandom);
            if ($urandom_range(0, 15) == 0) rb = '0;
            if ($urandom_range(0, 15) == 0) rb = DATA_W'($urandom_range(0, 3));
            ref_div(ra, rb, rq, ru);
            run_op("rand", ra, rb, rq, ru);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
